// File: rtl/grf_multiport.sv
// grf_multiport: parametrised register file, N read / 1..2 write ports, bypass, hard-wired $0, busy scoreboard
//   clk, reset       : clock, synchronous active-high reset
//   we, wa, wd, wpc  : per-write-port enable, address, data, PC (PC only for the log)
//   ra, rd, rbusy    : per-read-port address, combinational data, busy flag
//   issue_en/addr    : mark a destination register busy when its producer issues
//   busy_vec         : full scoreboard, bit i = register i busy
module grf_multiport #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit BYPASS   = 1,
    parameter bit ZERO_REG = 1,
    parameter bit LOG_EN   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_WR-1:0]      we,
    input  logic [NUM_WR*AW-1:0]   wa,
    input  logic [NUM_WR*DW-1:0]   wd,
    input  logic [NUM_WR*32-1:0]   wpc,
    input  logic [NUM_RD*AW-1:0]   ra,
    output logic [NUM_RD*DW-1:0]   rd,
    output logic [NUM_RD-1:0]      rbusy,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_addr,
    output logic [(1<<AW)-1:0]     busy_vec
);
    localparam int NREG = 1 << AW;

    if (NUM_RD < 1 || NUM_RD > 4 || NUM_WR < 1 || NUM_WR > 2) begin : g_bad_param
        $error("grf_multiport: illegal NUM_RD=%0d / NUM_WR=%0d", NUM_RD, NUM_WR);
    end

    logic [DW-1:0]   mem [NREG];
    logic [NREG-1:0] busy, busy_nxt;

    // Write ports are widened to two internally; a missing port 1 is simply never enabled.
    logic [1:0]      we_x;
    logic [2*AW-1:0] wa_x;
    logic [2*DW-1:0] wd_x;
    logic [AW-1:0]   wa_a [2];
    logic [DW-1:0]   wd_a [2];
    logic [1:0]      eff;

    assign we_x    = 2'(we);
    assign wa_x    = (2*AW)'(wa);
    assign wd_x    = (2*DW)'(wd);
    assign wa_a[0] = wa_x[0 +: AW];
    assign wa_a[1] = wa_x[AW +: AW];
    assign wd_a[0] = wd_x[0 +: DW];
    assign wd_a[1] = wd_x[DW +: DW];

    // Port 0 is dropped entirely when port 1 targets the same register.
    assign eff[1] = we_x[1] && !(ZERO_REG && wa_a[1] == '0);
    assign eff[0] = we_x[0] && !(ZERO_REG && wa_a[0] == '0) && !(we_x[1] && wa_a[1] == wa_a[0]);

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [AW-1:0] a;
        assign a = ra[j*AW +: AW];
        assign rd[j*DW +: DW] = (ZERO_REG && a == '0)           ? '0 :
                                (BYPASS && eff[1] && wa_a[1] == a) ? wd_a[1] :
                                (BYPASS && eff[0] && wa_a[0] == a) ? wd_a[0] :
                                mem[a];
        assign rbusy[j] = busy[a] && !(ZERO_REG && a == '0);
    end

    // Clears first, then the issue set, so a new producer outranks the retiring one.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < 2; k++)
            if (eff[k]) busy_nxt[wa_a[k]] = 1'b0;
        if (issue_en && !(ZERO_REG && issue_addr == '0)) busy_nxt[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (eff[k]) mem[wa_a[k]] <= wd_a[k];
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

    if (LOG_EN) begin : g_log
        always_ff @(posedge clk) begin
            if (!reset)
                for (int k = 0; k < NUM_WR; k++)
                    if (eff[k]) $display("%d@%h: $%d <= %h", $time, wpc[k*32 +: 32], wa_a[k], wd_a[k]);
        end
    end
endmodule

// File: tb/tb_grf_multiport.sv
// tb_grf_multiport: directed table-driven bench for grf_multiport (2W bypass instance and 1W no-bypass instance)
module tb_grf_multiport;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Instance A: two write ports, bypass on.
    logic        a_reset;
    logic [1:0]  a_we;
    logic [9:0]  a_wa;
    logic [63:0] a_wd;
    logic [63:0] a_wpc;
    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_rbusy;
    logic        a_ie;
    logic [4:0]  a_ia;
    logic [31:0] a_bv;

    // Instance B: one write port, bypass off.
    logic        b_reset;
    logic [0:0]  b_we;
    logic [4:0]  b_wa;
    logic [31:0] b_wd;
    logic [31:0] b_wpc;
    logic [9:0]  b_ra;
    logic [63:0] b_rd;
    logic [1:0]  b_rbusy;
    logic        b_ie;
    logic [4:0]  b_ia;
    logic [31:0] b_bv;

    grf_multiport #(.NUM_WR(2), .BYPASS(1)) dut_a (
        .clk(clk), .reset(a_reset), .we(a_we), .wa(a_wa), .wd(a_wd), .wpc(a_wpc),
        .ra(a_ra), .rd(a_rd), .rbusy(a_rbusy), .issue_en(a_ie), .issue_addr(a_ia), .busy_vec(a_bv)
    );

    grf_multiport #(.NUM_WR(1), .BYPASS(0)) dut_b (
        .clk(clk), .reset(b_reset), .we(b_we), .wa(b_wa), .wd(b_wd), .wpc(b_wpc),
        .ra(b_ra), .rd(b_rd), .rbusy(b_rbusy), .issue_en(b_ie), .issue_addr(b_ia), .busy_vec(b_bv)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [31:0] ebv;
    } vec_t;

    vec_t tv [16];

    initial begin
        a_reset = 1; a_we = 0; a_wa = 0; a_wd = 0; a_wpc = 0; a_ra = 0; a_ie = 0; a_ia = 0;
        b_reset = 1; b_we = 0; b_wa = 0; b_wd = 0; b_wpc = 0; b_ra = 0; b_ie = 0; b_ia = 0;
        // rd0/rd1/rbusy/busy_vec are the values seen before the posedge that commits the row.
        tv[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0};
        tv[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd3, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0};
        tv[2]  = '{2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 2'b00, 32'h0};
        tv[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 2'b00, 32'h0};
        tv[4]  = '{2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 1'b0, 5'd0, 5'd7, 5'd5, 32'h2, 32'hDEADBEEF, 2'b00, 32'h0};
        tv[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 32'h2, 32'h0, 2'b00, 32'h0};
        tv[6]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd7, 32'h0, 32'h2, 2'b00, 32'h0};
        tv[7]  = '{2'b01, 5'd9, 32'hAA, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd7, 32'hAA, 32'h2, 2'b01, 32'h200};
        tv[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'hAA, 32'hAA, 2'b11, 32'h200};
        tv[9]  = '{2'b01, 5'd9, 32'hBB, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd7, 32'hBB, 32'h2, 2'b01, 32'h200};
        tv[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd9, 5'd0, 32'hBB, 32'h0, 2'b00, 32'h0};
        tv[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'hBB, 2'b00, 32'h0};
        tv[12] = '{2'b11, 5'd3, 32'h33, 5'd4, 32'h44, 1'b0, 5'd0, 5'd3, 5'd4, 32'h33, 32'h44, 2'b00, 32'h0};
        tv[13] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4, 32'h33, 32'h44, 2'b00, 32'h0};
        tv[14] = '{2'b10, 5'd0, 32'h0, 5'd0, 32'hFF, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h2, 2'b00, 32'h0};
        tv[15] = '{2'b11, 5'd6, 32'h66, 5'd6, 32'h0, 1'b0, 5'd0, 5'd6, 5'd0, 32'h0, 32'h0, 2'b00, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        a_reset = 0; b_reset = 0;

        // All registers read zero on both ports after reset, nothing busy.
        for (int i = 0; i < 32; i++) begin
            a_ra = {5'(31 - i), 5'(i)};
            #1;
            chk("rst_rd0", a_rd[31:0], 32'h0);
            chk("rst_rd1", a_rd[63:32], 32'h0);
        end
        chk("rst_busy_a", a_bv, 32'h0);
        chk("rst_busy_b", b_bv, 32'h0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_we = tv[i].we; a_wa = {tv[i].wa1, tv[i].wa0}; a_wd = {tv[i].wd1, tv[i].wd0};
            a_wpc = {32'h1000 + 32'(i), 32'h2000 + 32'(i)};
            a_ie = tv[i].ie; a_ia = tv[i].ia; a_ra = {tv[i].ra1, tv[i].ra0};
            #1;
            chk($sformatf("v%0d_rd0", i), a_rd[31:0], tv[i].e0);
            chk($sformatf("v%0d_rd1", i), a_rd[63:32], tv[i].e1);
            chk($sformatf("v%0d_rbusy", i), 32'(a_rbusy), 32'(tv[i].eb));
            chk($sformatf("v%0d_bv", i), a_bv, tv[i].ebv);
        end
        @(negedge clk);
        a_we = 0; a_ie = 0; a_ra = {5'd0, 5'd6};
        #1;
        chk("dual_same_addr_commit", a_rd[31:0], 32'h0);

        // No-bypass instance: new data only visible the cycle after the write.
        @(negedge clk);
        b_we = 1; b_wa = 5; b_wd = 32'hDEADBEEF; b_wpc = 32'h400; b_ra = {5'd0, 5'd5};
        #1;
        chk("nobyp_same_cycle", b_rd[31:0], 32'h0);
        @(negedge clk);
        b_we = 1; b_wa = 0; b_wd = 32'h1234;
        #1;
        chk("nobyp_next_cycle", b_rd[31:0], 32'hDEADBEEF);
        @(negedge clk);
        b_we = 0; b_ra = {5'd5, 5'd0};
        #1;
        chk("nobyp_zero_reg", b_rd[31:0], 32'h0);
        chk("nobyp_rd1", b_rd[63:32], 32'hDEADBEEF);
        chk("nobyp_busy0", b_bv, 32'h0);

        // Fill regs 1..31, then reset together with a write and an issue.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            a_we = 2'b01; a_wa = {5'd0, 5'(i)}; a_wd = {32'h0, 32'h01010101 * 32'(i)};
        end
        @(negedge clk);
        a_we = 0; a_ie = 1; a_ia = 5'd20; a_ra = {5'd31, 5'd17};
        #1;
        chk("fill_r17", a_rd[31:0], 32'h11111111);
        chk("fill_r31", a_rd[63:32], 32'h1F1F1F1F);
        @(negedge clk);
        a_ie = 0;
        #1;
        chk("fill_busy20", a_bv, 32'h00100000);
        @(negedge clk);
        a_reset = 1; a_we = 2'b01; a_wa = {5'd0, 5'd5}; a_wd = {32'h0, 32'hFFFF}; a_ie = 1; a_ia = 5'd12;
        @(negedge clk);
        a_reset = 0; a_we = 0; a_ie = 0;
        for (int i = 0; i < 32; i++) begin
            a_ra = {5'(31 - i), 5'(i)};
            #1;
            chk("mid_rst_rd0", a_rd[31:0], 32'h0);
            chk("mid_rst_rd1", a_rd[63:32], 32'h0);
        end
        chk("mid_rst_busy", a_bv, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
